pixel_mem_axi4_slave: RTL



---
 rtl/dvp_pxl_mem_pkg.sv | 20 ++
 rtl/pixel_mem_addr_gen.sv | 64 ++++++
 rtl/pixel_mem_axi4_slave.sv | 113 +++++++++++
 3 files changed

// File: rtl/dvp_pxl_mem_pkg.sv
// Shared constants for the pixel frame-buffer AXI4 write slave:
// B response codes, FSM state encoding and the per-beat byte shift.
package dvp_pxl_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // One 256-bit beat spans 32 bytes.
    localparam int BEAT_SHIFT = 5;

    typedef struct packed {
        logic wr;
        logic err;
    } beat_chk_t;

endpackage

// File: rtl/pixel_mem_addr_gen.sv
// Beat address generation and per-beat error checks for the frame-buffer slave.
// Define PXL_MEM_WRAP_EN to make out-of-range beats wrap around the buffer.
module pixel_mem_addr_gen
    import dvp_pxl_mem_pkg::*;
#(
    parameter int                ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] MEM_BASE_ADDR = 32'h8000_0000,
    parameter int                MEM_DEPTH     = 1024,
    parameter int                MEM_ADDR_W    = 10,
    parameter int                MAX_BEATS     = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  aw_fire,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic                  beat_fire,
    output logic [MEM_ADDR_W-1:0] beat_addr,
    output beat_chk_t             beat_chk,
    output logic                  burst_err
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    logic [ADDR_W-1:0] base_word;
    logic [ADDR_W-1:0] cur_word;
    logic [CNT_W-1:0]  beat_cnt;
    logic              hdr_err;
    logic              over;
    logic              range_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_word <= '0;
            beat_cnt  <= '0;
            hdr_err   <= 1'b0;
            burst_err <= 1'b0;
        end else if (aw_fire) begin
            base_word <= (awaddr - MEM_BASE_ADDR) >> BEAT_SHIFT;
            beat_cnt  <= '0;
            hdr_err   <= (awaddr < MEM_BASE_ADDR) || (awaddr[BEAT_SHIFT-1:0] != '0);
            burst_err <= 1'b0;
        end else if (beat_fire) begin
            // Counter saturates so every beat past the limit keeps reporting over.
            if (beat_cnt != MAX_CNT)
                beat_cnt <= beat_cnt + 1'b1;
            burst_err <= burst_err | beat_chk.err;
        end
    end

    assign cur_word  = base_word + ADDR_W'(beat_cnt);
    assign over      = (beat_cnt == MAX_CNT);
    assign beat_addr = cur_word[MEM_ADDR_W-1:0];

`ifdef PXL_MEM_WRAP_EN
    assign range_err = 1'b0;
`else
    assign range_err = (cur_word >= ADDR_W'(MEM_DEPTH));
`endif

    assign beat_chk.err = hdr_err | over | range_err;
    assign beat_chk.wr  = ~beat_chk.err;

endmodule

// File: rtl/pixel_mem_axi4_slave.sv
// AXI4 write-only slave turning pixel bursts (ended by WLAST) into frame-buffer
// SRAM writes, one B response per burst. PXL_MEM_WRAP_EN enables ring addressing.
module pixel_mem_axi4_slave
    import dvp_pxl_mem_pkg::*;
#(
    parameter int                DATA_W        = 256,
    parameter int                ADDR_W        = 32,
    parameter int                MST_ID_W      = 5,
    parameter int                TRANS_RESP_W  = 2,
    parameter logic [ADDR_W-1:0] MEM_BASE_ADDR = 32'h8000_0000,
    parameter int                MEM_DEPTH     = 1024,
    parameter int                MEM_ADDR_W    = 10,
    parameter int                MAX_BEATS     = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MST_ID_W-1:0]     m_awid_i,
    input  logic [ADDR_W-1:0]       m_awaddr_i,
    input  logic                    m_awvalid_i,
    output logic                    m_awready_o,
    input  logic [DATA_W-1:0]       m_wdata_i,
    input  logic                    m_wlast_i,
    input  logic                    m_wvalid_i,
    output logic                    m_wready_o,
    output logic [MST_ID_W-1:0]     m_bid_o,
    output logic [TRANS_RESP_W-1:0] m_bresp_o,
    output logic                    m_bvalid_o,
    input  logic                    m_bready_i,
    output logic                    mem_wr_en_o,
    output logic [MEM_ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]       mem_wdata_o
);

    logic [1:0]            state;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  burst_err;
    logic [MEM_ADDR_W-1:0] beat_addr;
    beat_chk_t             beat_chk;

    // Ready outputs are only high in their own state, so no state qualifier is needed.
    assign aw_fire = m_awvalid_i & m_awready_o;
    assign w_fire  = m_wvalid_i & m_wready_o;

    pixel_mem_addr_gen #(
        .ADDR_W        (ADDR_W),
        .MEM_BASE_ADDR (MEM_BASE_ADDR),
        .MEM_DEPTH     (MEM_DEPTH),
        .MEM_ADDR_W    (MEM_ADDR_W),
        .MAX_BEATS     (MAX_BEATS)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .aw_fire   (aw_fire),
        .awaddr    (m_awaddr_i),
        .beat_fire (w_fire),
        .beat_addr (beat_addr),
        .beat_chk  (beat_chk),
        .burst_err (burst_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            m_awready_o <= 1'b0;
            m_wready_o  <= 1'b0;
            m_bvalid_o  <= 1'b0;
            m_bid_o     <= '0;
            m_bresp_o   <= '0;
            mem_wr_en_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            mem_wr_en_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (aw_fire) begin
                        m_awready_o <= 1'b0;
                        m_wready_o  <= 1'b1;
                        m_bid_o     <= m_awid_i;
                        state       <= DATA;
                    end else begin
                        m_awready_o <= 1'b1;
                    end
                end
                DATA: begin
                    if (w_fire) begin
                        mem_wr_en_o <= beat_chk.wr;
                        mem_addr_o  <= beat_addr;
                        mem_wdata_o <= m_wdata_i;
                        if (m_wlast_i) begin
                            m_wready_o <= 1'b0;
                            m_bvalid_o <= 1'b1;
                            // Last beat's own error is not yet folded into burst_err.
                            m_bresp_o  <= (burst_err | beat_chk.err) ?
                                          TRANS_RESP_W'(RESP_SLVERR) : TRANS_RESP_W'(RESP_OKAY);
                            state      <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (m_bready_i) begin
                        m_bvalid_o  <= 1'b0;
                        m_awready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
